// File: rtl/cpu_core_param.sv
// Parametrised multicycle accumulator core: FETCH/DECODE/EXEC controller, NREG register file,
// accumulator with Z flag, synchronous instruction read port and a wait-state tolerant data port.
module cpu_core_param #(
    parameter int DATA_W  = 16,
    parameter int NREG    = 8,
    parameter int ADDR_W  = 8,
    parameter int DADDR_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    output logic [ADDR_W-1:0]  iram_addr,
    input  logic [7:0]         iram_rdata,
    output logic               dram_req,
    output logic               dram_we,
    output logic [DADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0]  dram_wdata,
    input  logic [DATA_W-1:0]  dram_rdata,
    input  logic               dram_ack,
    output logic               finish
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_IMM, S_IMM_EXEC, S_MEM, S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0, OP_LDI = 4'h1, OP_MOV = 4'h2, OP_MVA = 4'h3,
                           OP_ADD = 4'h4, OP_SUB = 4'h5, OP_INC = 4'h6, OP_DEC = 4'h7,
                           OP_LDM = 4'h8, OP_STM = 4'h9, OP_JMP = 4'hA, OP_JPNZ = 4'hB,
                           OP_AND = 4'hC, OP_OR = 4'hD, OP_SHL = 4'hE, OP_END = 4'hF;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_pc, w_pc_d;
    logic [DATA_W-1:0]   r_ac, w_ac_d;
    logic                r_z, w_z_d, w_z_we, w_ac_we;
    logic [7:0]          r_ir;
    logic [DATA_W-1:0]   r_regs [NREG];
    logic                r_finish;
    logic                w_reg_we;
    logic [DATA_W-1:0]   w_reg_d;

    logic [3:0]          w_op, w_n, w_dec_op;
    logic [DATA_W-1:0]   w_rn, w_incdec, w_imm;

    assign w_op     = r_ir[7:4];
    assign w_n      = r_ir[3:0];
    assign w_dec_op = iram_rdata[7:4];
    assign w_imm    = DATA_W'(iram_rdata);
    assign w_incdec = (w_op == OP_INC) ? w_rn + DATA_W'(1) : w_rn - DATA_W'(1);

    // Indices beyond the register file read as zero.
    always_comb begin
        w_rn = '0;
        for (int i = 0; i < NREG; i++)
            if (w_n == 4'(i)) w_rn = r_regs[i];
    end

    assign iram_addr  = r_pc;
    assign dram_req   = (r_state == S_MEM);
    assign dram_we    = (r_state == S_MEM) && (w_op == OP_STM);
    assign dram_addr  = w_rn[DADDR_W-1:0];
    assign dram_wdata = r_ac;
    assign finish     = r_finish;

    always_comb begin
        w_next   = r_state;
        w_pc_d   = r_pc;
        w_ac_we  = 1'b0;
        w_ac_d   = r_ac;
        w_z_we   = 1'b0;
        w_z_d    = r_z;
        w_reg_we = 1'b0;
        w_reg_d  = r_ac;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                w_pc_d = r_pc + ADDR_W'(1);
                case (w_dec_op)
                    OP_LDI, OP_JMP, OP_JPNZ: w_next = S_IMM;
                    OP_LDM, OP_STM:          w_next = S_MEM;
                    OP_END:                  w_next = S_HALT;
                    default:                 w_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                w_next = S_FETCH;
                case (w_op)
                    OP_MOV: w_reg_we = 1'b1;
                    OP_MVA: begin w_ac_we = 1'b1; w_ac_d = w_rn;         end
                    OP_ADD: begin w_ac_we = 1'b1; w_ac_d = r_ac + w_rn;  end
                    OP_SUB: begin w_ac_we = 1'b1; w_ac_d = r_ac - w_rn;  end
                    OP_AND: begin w_ac_we = 1'b1; w_ac_d = r_ac & w_rn;  end
                    OP_OR:  begin w_ac_we = 1'b1; w_ac_d = r_ac | w_rn;  end
                    OP_SHL: begin w_ac_we = 1'b1; w_ac_d = r_ac << 1;    end
                    OP_INC, OP_DEC: begin
                        // Z follows the computed value even when the write is dropped.
                        w_reg_we = 1'b1;
                        w_reg_d  = w_incdec;
                        w_z_we   = 1'b1;
                        w_z_d    = (w_incdec == '0);
                    end
                    default: ;
                endcase
            end
            S_IMM: w_next = S_IMM_EXEC;
            S_IMM_EXEC: begin
                w_next = S_FETCH;
                if (w_op == OP_JMP || (w_op == OP_JPNZ && !r_z))
                    w_pc_d = iram_rdata[ADDR_W-1:0];
                else
                    w_pc_d = r_pc + ADDR_W'(1);
                if (w_op == OP_LDI) begin
                    w_ac_we = 1'b1;
                    w_ac_d  = w_imm;
                end
            end
            S_MEM: begin
                if (dram_ack) begin
                    w_next = S_FETCH;
                    if (w_op == OP_LDM) begin
                        w_ac_we = 1'b1;
                        w_ac_d  = dram_rdata;
                    end
                end
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
        if (w_ac_we) begin
            w_z_we = 1'b1;
            w_z_d  = (w_ac_d == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_ac     <= '0;
            r_z      <= 1'b0;
            r_ir     <= '0;
            r_finish <= 1'b0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_d;
            if (r_state == S_DECODE) r_ir <= iram_rdata;
            if (w_ac_we) r_ac <= w_ac_d;
            if (w_z_we)  r_z  <= w_z_d;
            if (r_state == S_DECODE && w_dec_op == OP_END) r_finish <= 1'b1;
            for (int i = 0; i < NREG; i++)
                if (w_reg_we && w_n == 4'(i)) r_regs[i] <= w_reg_d;
        end
    end

endmodule

// File: doc/cpu_core_param.md
Name: cpu_core_param

Overview:
- Parametrised successor to the fixed 16-bit accumulator CPU top level: one multicycle accumulator core with configurable data width, register count and program-counter width.
- Contains a FETCH/DECODE/EXEC controller, an NREG-entry register file, an accumulator with Z flag, a synchronous instruction-memory read port and a data-memory req/ack port that tolerates wait states.
- Asserts a sticky finish on END.

Parameters:
- DATA_W, 16: accumulator, register and data-memory word width (4..32).
- NREG, 8: number of general registers (1..16).
- ADDR_W, 8: PC and iram_addr width (1..8).
- DADDR_W, 8: data-memory address width (≤DATA_W).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- iram_addr  out  ADDR_W  instruction address; always equals PC.
- iram_rdata  in  8  instruction word; valid one cycle after iram_addr.
- dram_req  out  1  data-memory request.
- dram_we  out  1  1 = write, 0 = read; valid with dram_req.
- dram_addr  out  DADDR_W  Rn[DADDR_W-1:0].
- dram_wdata  out  DATA_W  AC.
- dram_rdata  in  DATA_W  read data; sampled on the cycle dram_ack is high.
- dram_ack  in  1  completes the request.
- finish  out  1  high in HALT; sticky until reset.

Behaviour:
- Instruction format: opcode = [7:4], n = [3:0].
- Opcodes:
  - 0 NOP.
  - 1 LDI: AC←next word, zero-extended.
  - 2 MOV: Rn←AC.
  - 3 MVA: AC←Rn.
  - 4 ADD: AC←AC+Rn.
  - 5 SUB: AC←AC−Rn.
  - 6 INC: Rn←Rn+1.
  - 7 DEC: Rn←Rn−1.
  - 8 LDM: AC←dmem[Rn].
  - 9 STM: dmem[Rn]←AC.
  - A JMP: PC←next word.
  - B JPNZ: PC←next word if Z=0, else PC←PC+1.
  - C AND: AC←AC&Rn.
  - D OR: AC←AC|Rn.
  - E SHL: AC←AC<<1, LSB filled with 0.
  - F END.
- Arithmetic is modulo 2^DATA_W; no carry is kept.
- Z is updated on every write to AC, and on INC/DEC from the register result; no other instruction changes Z.
- Register index n ≥ NREG: reads return 0, writes are dropped; for INC/DEC, Z is set from the computed value 0±1.
- JMP/JPNZ targets use next word [ADDR_W-1:0]; the PC wraps at 2^ADDR_W.
- Reset: PC, AC, every Rn, IR and Z = 0; dram_req = 0, dram_we = 0, finish = 0; state = FETCH. Reset overrides everything, including a pending memory request; dram_req falls on the edge where reset is sampled.
- FETCH: present PC → DECODE.
- DECODE: IR←iram_rdata, PC←PC+1. Next state:
  - opcode 1/A/B → IMM.
  - 8/9 → MEM.
  - F → HALT.
  - otherwise → EXEC.
- EXEC: perform the single-word operation → FETCH.
- IMM: present PC (the operand word) → IMM_EXEC.
- IMM_EXEC: use iram_rdata as the operand; LDI/not-taken JPNZ set PC←PC+1; JMP/taken JPNZ load the target → FETCH.
- MEM:
  - dram_req = 1, with we/addr/wdata held stable until a cycle with dram_ack = 1.
  - On that edge, LDM loads AC and Z, and dram_req drops.
  - Next state FETCH.
- dram_ack is ignored when dram_req = 0.
- HALT: finish = 1, no further fetch, PC frozen. Only reset leaves HALT.
- Latency, from FETCH entry to the next FETCH entry:
  - EXEC-class instructions: 3 cycles.
  - IMM-class instructions: 4 cycles.
  - MEM-class instructions: 3 + W cycles, where W is the number of wait cycles before ack (ack on the first MEM cycle gives W = 0).
- finish is registered and asserts the cycle after the DECODE of END.

Test Plan:
- Reset with arbitrary prior state → PC = 0, AC = 0, all Rn = 0, Z = 0, finish = 0, dram_req = 0; iram_addr = 0 on the first cycle after reset.
- Program 10 05 / 20 / 10 03 / 40 / F0 (LDI 5, MOV R0, LDI 3, ADD R0, END) → AC = 8, R0 = 5, Z = 0; finish asserts after 4+3+4+3+2 = 16 cycles from reset release.
- Countdown loop: LDI 3; MOV R1; DEC R1; JPNZ 3; END → DEC executes 3 times, R1 = 0, JPNZ falls through, END reached, finish = 1.
- STM then LDM via R2 = 0x12 with dram_ack delayed 3 cycles → dram_req high 4 cycles each with we/addr/wdata stable; AC reloads the stored value; Z is correct.
- With NREG = 4, MOV R9 then MVA R9 → no register changes; AC = 0, Z = 1. With DATA_W = 8, LDI FF then INC on AC via MOV/INC R0 → R0 = 0x00, Z = 1.
- Reset asserted during MEM wait (ack never given) → dram_req = 0 on the next cycle; the core refetches from PC = 0; END → finish stays high for 20 cycles until reset.
